// File: rtl/detector_sched_pkg.sv
// Shared types and defaults for the detector scheduler.
// Combinational definitions only; no latency.
// No flow control of its own.
package detector_sched_pkg;

  localparam int DEF_N = 2;
  localparam int DEF_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/detector_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping mod N.
// Purely combinational, zero latency.
// No backpressure; grant is zero when nothing is requesting.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/detector_scheduler.sv
// Time-shares one serial pattern detector among N requesters, returning a 1-count per word.
// Latency: request accept to rsp_valid is W+2 cycles; W+4 cycles minimum per transaction.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
module detector_scheduler
  import detector_sched_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = $clog2(N),
  parameter int CW  = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           fsm_clr,
  output logic           fsm_in,
  input  logic           fsm_out,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [CW-1:0]  rsp_count,
  input  logic           rsp_ready
);

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]  count_q, count_d;

  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      id_q      <= '0;
      rr_q      <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    rr_d      = rr_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    req_ready = '0;
    fsm_clr   = 1'b0;
    fsm_in    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (|req_valid) begin
          shreg_d = req_data[int'(gnt_idx)*W +: W];
          id_d    = gnt_idx;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        fsm_clr   = 1'b1;
        bit_cnt_d = '0;
        count_d   = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        fsm_in    = shreg_q[W-1];
        shreg_d   = {shreg_q[W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CW'(1);
        // First cycle's fsm_out still shows the cleared state, not a data bit.
        if (bit_cnt_q != '0 && fsm_out) count_d = count_q + CW'(1);
        if (bit_cnt_q == CW'(W - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fsm_out) count_d = count_q + CW'(1);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rr_d    = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_id    = id_q;
  assign rsp_count = count_q;

endmodule
